// File: rtl/io_input_sampler.sv
// io_input_sampler: memory-mapped input front end for the processor load path.
// Raw switches and active-low push-buttons are brought into the clock domain
// through two-flop synchronisers. Buttons are debounced and latch sticky press
// events. Three zero-extended 32-bit words are presented to the load-data mux.
// Optional build macro: IO_SW_DEBOUNCE_EN gives every switch bit its own
// debouncer. No switch events are generated in either build.

// Per-bit debouncer: four-state FSM with a stable-cycle counter.
// o_level is registered. o_press is high during the cycle whose closing edge
// moves the FSM from the press side into HELD.
module io_input_sampler_deb #(
  parameter int DEB_CYCLES = 50000,
  parameter int CNT_W      = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_p,
  output logic o_level,
  output logic o_press
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CNT   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CNT = 2'd3
  } deb_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam bit               ONE_CYCLE = (DEB_CYCLES == 1);

  deb_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;

  // Only press-side entries into HELD count as events. A release bounce that
  // falls back from RELEASE_CNT to HELD is part of the same hold and must not
  // raise a second event.
  assign o_press = i_p && ((state_reg == RELEASED && ONE_CYCLE) ||
                           (state_reg == PRESS_CNT && cnt_reg == CNT_LAST));
  assign o_level = level_reg;

  // Debounce FSM: accept a level change only after DEB_CYCLES stable cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= RELEASED;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else begin
      case (state_reg)
        RELEASED: begin
          cnt_reg <= '0;
          if (i_p) begin
            if (ONE_CYCLE) begin
              state_reg <= HELD;
              level_reg <= 1'b1;
            end else begin
              state_reg <= PRESS_CNT;
              cnt_reg   <= CNT_W'(1);
            end
          end
        end
        PRESS_CNT: begin
          if (!i_p) begin
            state_reg <= RELEASED;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= HELD;
            level_reg <= 1'b1;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HELD: begin
          cnt_reg <= '0;
          if (!i_p) begin
            if (ONE_CYCLE) begin
              state_reg <= RELEASED;
              level_reg <= 1'b0;
            end else begin
              state_reg <= RELEASE_CNT;
              cnt_reg   <= CNT_W'(1);
            end
          end
        end
        RELEASE_CNT: begin
          if (i_p) begin
            state_reg <= HELD;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= RELEASED;
            level_reg <= 1'b0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= RELEASED;
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

module io_input_sampler #(
  parameter int NUM_SW     = 18,
  parameter int NUM_BTN    = 4,
  parameter int DEB_CYCLES = 50000,
  parameter int CNT_W      = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SW-1:0]  i_sw,
  input  logic [NUM_BTN-1:0] i_btn,
  input  logic               i_evt_clr,
  input  logic [NUM_BTN-1:0] i_evt_clr_mask,
  output logic [31:0]        o_sw_word,
  output logic [31:0]        o_btn_word,
  output logic [31:0]        o_evt_word,
  output logic               o_evt_any
);

  logic [NUM_SW-1:0]  sw_s1_reg;
  logic [NUM_SW-1:0]  sw_s2_reg;
  logic [NUM_BTN-1:0] btn_s1_reg;
  logic [NUM_BTN-1:0] btn_s2_reg;

  logic [NUM_SW-1:0]  sw_level;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] clr_sel;
  logic [NUM_BTN-1:0] evt_next;
  logic [NUM_BTN-1:0] evt_reg;
  logic               evt_any_reg;

  // Two-flop synchronisers; buttons reset to the released (high) level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_s1_reg  <= '0;
      sw_s2_reg  <= '0;
      btn_s1_reg <= '1;
      btn_s2_reg <= '1;
    end else begin
      sw_s1_reg  <= i_sw;
      sw_s2_reg  <= sw_s1_reg;
      btn_s1_reg <= i_btn;
      btn_s2_reg <= btn_s1_reg;
    end
  end

  // One debouncer per button, fed with the pressed level (buttons are active-low).
  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    io_input_sampler_deb #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_p    (~btn_s2_reg[gi]),
      .o_level(btn_level[gi]),
      .o_press(btn_press[gi])
    );
  end

`ifdef IO_SW_DEBOUNCE_EN
  // Switches share the button debouncer; their press strobes are discarded.
  logic [NUM_SW-1:0] sw_press_unused;
  for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
    io_input_sampler_deb #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_p    (sw_s2_reg[gi]),
      .o_level(sw_level[gi]),
      .o_press(sw_press_unused[gi])
    );
  end
`else
  assign sw_level = sw_s2_reg;
`endif

  // Sticky flags: a press on the same edge as a clear wins.
  always_comb begin
    clr_sel  = i_evt_clr ? i_evt_clr_mask : '0;
    evt_next = (evt_reg & ~clr_sel) | btn_press;
  end

  // Event flag register; the summary bit is registered from the same next value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      evt_reg     <= '0;
      evt_any_reg <= 1'b0;
    end else begin
      evt_reg     <= evt_next;
      evt_any_reg <= |evt_next;
    end
  end

  // Zero-extend the register-driven fields onto the 32-bit load path.
  always_comb begin
    o_sw_word                = '0;
    o_btn_word               = '0;
    o_evt_word               = '0;
    o_sw_word[NUM_SW-1:0]    = sw_level;
    o_btn_word[NUM_BTN-1:0]  = btn_level;
    o_evt_word[NUM_BTN-1:0]  = evt_reg;
    o_evt_any                = evt_any_reg;
  end

endmodule

// File: tb/tb_io_input_sampler.sv
// Bench for io_input_sampler with DEB_CYCLES=4. Stimulus pushes expected
// output words tagged with the edge count after which they must hold; a
// monitor on the falling edge pops and compares them.
module tb_io_input_sampler;

`ifdef IO_SW_DEBOUNCE_EN
  localparam int SWL = 6;
`else
  localparam int SWL = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic [17:0] sw;
  logic [3:0]  btn;
  logic        evt_clr;
  logic [3:0]  evt_clr_mask;
  logic [31:0] sw_word;
  logic [31:0] btn_word;
  logic [31:0] evt_word;
  logic        evt_any;

  io_input_sampler #(
    .NUM_SW    (18),
    .NUM_BTN   (4),
    .DEB_CYCLES(4),
    .CNT_W     (16)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sw          (sw),
    .i_btn         (btn),
    .i_evt_clr     (evt_clr),
    .i_evt_clr_mask(evt_clr_mask),
    .o_sw_word     (sw_word),
    .o_btn_word    (btn_word),
    .o_evt_word    (evt_word),
    .o_evt_any     (evt_any)
  );

  typedef struct {
    int          at_edge;
    string       name;
    logic [31:0] sw;
    logic [31:0] btn;
    logic [31:0] evt;
    logic        any;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic push(input int at, input string name, input logic [31:0] s,
                      input logic [31:0] b, input logic [31:0] e, input logic a);
    exp_t x;
    x.at_edge = at; x.name = name; x.sw = s; x.btn = b; x.evt = e; x.any = a;
    sb.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic cmp32(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s edge=%0d got=%h want=%h", name, field, edge_cnt, act, req);
    end
  endtask

  // Monitor: compare every expectation due after the most recent edge.
  always @(negedge clk) begin
    exp_t x;
    while (sb.size() > 0 && sb[0].at_edge < edge_cnt) begin
      x = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s missed: due edge %0d, now %0d", x.name, x.at_edge, edge_cnt);
    end
    while (sb.size() > 0 && sb[0].at_edge == edge_cnt) begin
      x = sb.pop_front();
      cmp32(x.name, "sw",  sw_word,  x.sw);
      cmp32(x.name, "btn", btn_word, x.btn);
      cmp32(x.name, "evt", evt_word, x.evt);
      cmp32(x.name, "any", {31'd0, evt_any}, {31'd0, x.any});
      $display("check %-14s edge=%0d sw=%h btn=%h evt=%h any=%0b",
               x.name, edge_cnt, sw_word, btn_word, evt_word, evt_any);
    end
  end

  initial begin
    int e;
    rst_n = 1'b0; btn = 4'h0; sw = '0; evt_clr = 1'b0; evt_clr_mask = 4'h0;

    // Reset with all buttons pressed, then release reset while still held.
    step(3);
    e = edge_cnt;
    push(e, "reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    push(e + 5, "rst_rel_wait", 0, 0, 0, 0);
    push(e + 6, "rst_rel_held", 0, 32'hF, 32'hF, 1);
    step(8);

    // Release all buttons: level drops after the same latency, events stay.
    e = edge_cnt; btn = 4'hF;
    push(e + 5, "rel_all_wait", 0, 32'hF, 32'hF, 1);
    push(e + 6, "rel_all", 0, 0, 32'hF, 1);
    step(8);

    e = edge_cnt; evt_clr = 1'b1; evt_clr_mask = 4'hF;
    push(e + 1, "clr_all", 0, 0, 0, 0);
    step(1); evt_clr = 1'b0; evt_clr_mask = 4'h0; step(2);

    // Clean press and release of button 2.
    e = edge_cnt; btn = 4'b1011;
    push(e + 5, "press2_wait", 0, 0, 0, 0);
    push(e + 6, "press2", 0, 32'h4, 32'h4, 1);
    step(10);
    e = edge_cnt; btn = 4'hF;
    push(e + 5, "rel2_wait", 0, 32'h4, 32'h4, 1);
    push(e + 6, "rel2", 0, 0, 32'h4, 1);
    step(8);
    e = edge_cnt; evt_clr = 1'b1; evt_clr_mask = 4'b0100;
    push(e + 1, "clr2", 0, 0, 0, 0);
    step(1); evt_clr = 1'b0; evt_clr_mask = 4'h0; step(2);

    // Bounce on button 0, then hold pressed.
    btn = 4'b1110; step(1);
    btn = 4'b1111; step(1);
    btn = 4'b1110; step(1);
    btn = 4'b1111; step(1);
    e = edge_cnt; btn = 4'b1110;
    push(e, "bounce_mid", 0, 0, 0, 0);
    push(e + 5, "bounce_wait", 0, 0, 0, 0);
    step(5);
    // Clear strobe lands on the same edge the FSM enters HELD: set wins.
    evt_clr = 1'b1; evt_clr_mask = 4'b0001;
    push(e + 6, "clr_vs_set", 0, 32'h1, 32'h1, 1);
    step(1); evt_clr = 1'b0; evt_clr_mask = 4'h0; step(2);
    evt_clr = 1'b1; evt_clr_mask = 4'b0001;
    push(edge_cnt + 1, "clr_after", 0, 32'h1, 0, 0);
    step(1); evt_clr = 1'b0; evt_clr_mask = 4'h0; step(1);
    e = edge_cnt; btn = 4'hF;
    push(e + 6, "bounce_rel", 0, 0, 0, 0);
    step(8);

    // Switch patterns.
    e = edge_cnt; sw = 18'h2A5A5;
    push(e + SWL - 1, "sw1_wait", 0, 0, 0, 0);
    push(e + SWL, "sw1", 32'h0002A5A5, 0, 0, 0);
    step(SWL + 2);
    e = edge_cnt; sw = 18'h15A5A;
    push(e + SWL - 1, "sw2_wait", 32'h0002A5A5, 0, 0, 0);
    push(e + SWL, "sw2", 32'h00015A5A, 0, 0, 0);
    step(SWL + 2);
    e = edge_cnt; sw = 18'h0;
    push(e + SWL, "sw_zero", 0, 0, 0, 0);
    step(SWL + 2);

    // Async reset in the middle of a press count, with button 3 already HELD.
    e = edge_cnt; btn = 4'b0111;
    push(e + 6, "b3_held", 0, 32'h8, 32'h8, 1);
    step(8);
    btn = 4'b0101;
    step(3);
    rst_n = 1'b0;
    push(edge_cnt, "async_rst", 0, 0, 0, 0);
    step(2);
    rst_n = 1'b1;
    e = edge_cnt;
    push(e + 5, "post_rst_wait", 0, 0, 0, 0);
    push(e + 6, "post_rst_held", 0, 32'hA, 32'hA, 1);
    step(8);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 100 && sb.size() > 0; i++) step(1);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_input_sampler.md
# io_input_sampler

Memory-mapped input front end for the single-cycle processor's I/O load path. It synchronises the raw board switches and push-buttons, debounces the buttons, and keeps sticky press-event flags. It presents three zero-extended 32-bit words to the load-data selection mux, where they are chosen alongside data memory and the output-register readback.

## Interface
- `NUM_SW`, default 18: number of slide switches (1..32).
- `NUM_BTN`, default 4: number of push-buttons (1..32).
- `DEB_CYCLES`, default 50000: consecutive stable cycles required to accept a debounced level change (>= 1).
- `CNT_W`, default 16: debounce counter width; must satisfy `DEB_CYCLES <= 2**CNT_W`.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_sw`, in, `NUM_SW`: raw switches, active-high, asynchronous to `i_clk`.
- `i_btn`, in, `NUM_BTN`: raw buttons, active-low (0 = pressed), asynchronous to `i_clk`.
- `i_evt_clr`, in, 1: single-cycle strobe that clears event flags selected by `i_evt_clr_mask`.
- `i_evt_clr_mask`, in, `NUM_BTN`: per-button clear mask, sampled when `i_evt_clr` = 1.
- `o_sw_word`, out, 32: synchronised switch levels, zero-extended.
- `o_btn_word`, out, 32: debounced button levels, 1 = pressed, zero-extended.
- `o_evt_word`, out, 32: sticky press-event flags, zero-extended.
- `o_evt_any`, out, 1: OR of all event flags (interrupt-style level).

## Operation
- Every `i_sw` and `i_btn` bit passes through a two-flop synchroniser, stages s1 then s2.
- `o_sw_word[NUM_SW-1:0]` = s2 of the switches. Switches are not debounced unless the configuration macro is set.
- Each button has an independent FSM and counter `cnt`, operating on `p = ~s2` (1 = pressed):
  - **RELEASED**: `o_btn_word` bit = 0. If `p` = 1, go to PRESS_CNT with `cnt` = 1; if `DEB_CYCLES` = 1, go directly to HELD instead.
  - **PRESS_CNT**: if `p` = 0, return to RELEASED with `cnt` = 0. If `cnt` = `DEB_CYCLES`-1 and `p` = 1, go to HELD. Otherwise increment `cnt`.
  - **HELD**: `o_btn_word` bit = 1. If `p` = 0, go to RELEASE_CNT (mirror of PRESS_CNT; `DEB_CYCLES` = 1 goes directly to RELEASED).
  - **RELEASE_CNT**: if `p` = 1, return to HELD. On reaching `DEB_CYCLES` stable cycles, go to RELEASED.
- Event flags:
  - An event flag is set on the clock edge where its FSM enters HELD.
  - A flag is cleared on an edge where `i_evt_clr` = 1 and its mask bit = 1.
  - If set and clear occur on the same edge, set wins.
- Unused upper bits of all three words are 0.
- Releases never set events. Holding a button generates exactly one event.

## Timing
- Reset (async assert, `i_rst_n` = 0) puts all outputs at 0: s1/s2 = 0 for switches and 1 for buttons (released), FSMs in RELEASED, counters 0, events 0. Release of reset is synchronous to the next edge.
- A reset asserted mid-count or while HELD discards the count and any pending event.
- Switch latency: an input change that meets setup before edge N appears on `o_sw_word` after edge N+1.
- Button press latency: an input stable from before edge N sets `o_btn_word` and the event flag after edge N+1+`DEB_CYCLES`. Release latency is identical.
- A single-cycle glitch in `p` restarts the count. A bounce train shorter than `DEB_CYCLES` stable cycles produces no output change.
- `i_evt_clr` takes effect on the same edge. `o_evt_word` and `o_evt_any` update after that edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `IO_SW_DEBOUNCE_EN` defined: each switch bit gets the same FSM and counter as a button, using the active-high level. Switch latency becomes 2+`DEB_CYCLES` edges. No switch events are generated.
- `IO_SW_DEBOUNCE_EN` undefined: switches use the synchroniser only (latency as above). No switch counters are instantiated.

## Test plan
- **Reset:** with `DEB_CYCLES`=4, hold `i_rst_n`=0 with all `i_btn`=0 (pressed) → all outputs 0. Release reset with buttons held → `o_btn_word`=32'h0000000F after 2+4 edges; `o_evt_word`=32'h0000000F.
- **Clean press/release:** `i_btn[2]` 1→0 before edge 10 → `o_btn_word`=32'h4 and `o_evt_any`=1 after edge 15. `i_btn[2]` 0→1 before edge 30 → `o_btn_word`=0 after edge 35; event still 32'h4.
- **Bounce:** `i_btn[0]` toggles 0,1,0,1 on alternate cycles, then holds 0 → no change during bouncing. `o_btn_word`=32'h1 exactly 6 edges after the last toggle.
- **Clear vs set:** `i_evt_clr`=1 with mask 4'b0001 on the same edge button 0 enters HELD → bit 0 stays 1. Pulse the clear again with the same mask → `o_evt_word`=0 and `o_evt_any`=0 after that edge.
- **Switches:** `i_sw`=18'h2A5A5 before edge 20 → `o_sw_word`=32'h0002A5A5 after edge 21. With `IO_SW_DEBOUNCE_EN` defined, it appears after edge 25.
- **Async reset mid-count:** assert `i_rst_n`=0 mid-PRESS_CNT, between edges → outputs 0 immediately, no event after release until a fresh 2+4-edge press completes.
